cache_ctrl: RTL and testbench

CACHE_CTRL -- requirements
Module: cache_ctrl

---
 rtl/cache_ctrl_if.sv | 29 ++
 rtl/cache_ctrl.sv | 113 +++++++++++
 tb/tb_cache_ctrl.sv | 174 +++++++++++++++++
 3 files changed

// File: rtl/cache_ctrl_if.sv
// Bus bundle between the cache controller, the CPU pipeline, the cache set and memory.
`default_nettype none

interface cache_ctrl_if;
  logic        MemRead;
  logic        MemWrite;
  logic [31:0] Addr;
  logic        Hit;
  logic        Dirty;
  logic [25:0] OutTag;
  logic        MemReady;
  logic [6:0]  Ctls;
  logic        Stall;
  logic        MemReq;
  logic        MemWE;
  logic [31:0] MemAddr;

  modport master (
    input  MemRead, MemWrite, Addr, Hit, Dirty, OutTag, MemReady,
    output Ctls, Stall, MemReq, MemWE, MemAddr
  );

  modport slave (
    output MemRead, MemWrite, Addr, Hit, Dirty, OutTag, MemReady,
    input  Ctls, Stall, MemReq, MemWE, MemAddr
  );
endinterface

`default_nettype wire

// File: rtl/cache_ctrl.sv
// Write-back cache controller: hit check, dirty writeback burst and 4-beat refill.
// Rev 1.0
`default_nettype none

module cache_ctrl (
  input  wire logic     CLK,
  input  wire logic     Reset,
  cache_ctrl_if.master  bus
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    CHECK  = 2'd1,
    WB     = 2'd2,
    REFILL = 2'd3
  } state_t;

  state_t     state;
  logic [1:0] cnt;

  logic       req;
  logic       done;
  logic       wen;
  logic       set_valid;
  logic       set_dirty;
  logic [1:0] offset;
  logic       init;
  logic       offset_sw;
  logic       unused_addr_bits;

  assign req              = bus.MemRead | bus.MemWrite;
  assign done             = (state == CHECK) & bus.Hit;
  assign unused_addr_bits = ^bus.Addr[1:0];

  always_ff @(posedge CLK or negedge Reset) begin
    if (!Reset) begin
      state <= IDLE;
      cnt   <= 2'd0;
    end else begin
      case (state)
        IDLE: begin
          if (req) state <= CHECK;
        end
        CHECK: begin
          if (!req || bus.Hit) begin
            state <= IDLE;
          end else begin
            cnt   <= 2'd0;
            state <= bus.Dirty ? WB : REFILL;
          end
        end
        WB: begin
          if (bus.MemReady) begin
            cnt <= cnt + 2'd1;
            if (cnt == 2'd3) state <= REFILL;
          end
        end
        REFILL: begin
          if (bus.MemReady) begin
            cnt <= cnt + 2'd1;
            if (cnt == 2'd3) state <= CHECK;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  always_comb begin
    wen         = 1'b0;
    set_valid   = 1'b0;
    set_dirty   = 1'b0;
    offset      = 2'd0;
    init        = 1'b0;
    offset_sw   = 1'b0;
    bus.MemReq  = 1'b0;
    bus.MemWE   = 1'b0;
    bus.MemAddr = 32'd0;
    case (state)
      // Reset gates init so Ctls reads zero while Reset is low.
      IDLE: init = req & Reset;
      CHECK: begin
        if (bus.MemWrite && bus.Hit) begin
          wen       = 1'b1;
          set_valid = 1'b1;
          set_dirty = 1'b1;
          offset    = bus.Addr[3:2];
          offset_sw = 1'b1;
        end
      end
      WB: begin
        bus.MemReq  = 1'b1;
        bus.MemWE   = 1'b1;
        offset      = cnt;
        bus.MemAddr = {bus.OutTag, bus.Addr[5:4], cnt, 2'b00};
      end
      REFILL: begin
        bus.MemReq  = 1'b1;
        offset      = cnt;
        wen         = bus.MemReady;
        set_valid   = bus.MemReady & (cnt == 2'd3);
        bus.MemAddr = {bus.Addr[31:4], cnt, 2'b00};
      end
      default: ;
    endcase
  end

  assign bus.Ctls  = {wen, set_valid, set_dirty, offset, init, offset_sw};
  assign bus.Stall = req & ~done;

endmodule

`default_nettype wire

// File: tb/tb_cache_ctrl.sv
// Directed bench for cache_ctrl: hits, clean/dirty misses, backpressure and reset.
`default_nettype none

module tb_cache_ctrl;

  logic CLK = 1'b0;
  logic Reset;
  int   passed = 0;
  int   failed = 0;
  int   total  = 0;

  cache_ctrl_if bus ();

  cache_ctrl dut (
    .CLK   (CLK),
    .Reset (Reset),
    .bus   (bus)
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      failed++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic chk_all(input string tag, input logic [6:0] ctls, input logic stall,
                         input logic req, input logic we, input logic [31:0] addr);
    chk({tag, ".ctls"},  {25'd0, bus.Ctls},   {25'd0, ctls});
    chk({tag, ".stall"}, {31'd0, bus.Stall},  {31'd0, stall});
    chk({tag, ".req"},   {31'd0, bus.MemReq}, {31'd0, req});
    chk({tag, ".we"},    {31'd0, bus.MemWE},  {31'd0, we});
    chk({tag, ".addr"},  bus.MemAddr,         addr);
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  initial begin
    logic [6:0] e;

    Reset        = 1'b0;
    bus.MemRead  = 1'b0;
    bus.MemWrite = 1'b0;
    bus.Addr     = 32'd0;
    bus.Hit      = 1'b0;
    bus.Dirty    = 1'b0;
    bus.OutTag   = 26'd0;
    bus.MemReady = 1'b0;

    // Reset state, then a request held during reset
    @(negedge CLK);
    chk_all("rst", 7'b0000000, 1'b0, 1'b0, 1'b0, 32'd0);
    bus.MemRead = 1'b1;
    #1;
    chk_all("rst_req", 7'b0000000, 1'b1, 1'b0, 1'b0, 32'd0);
    bus.MemRead = 1'b0;
    tick();
    Reset = 1'b1;

    // Load hit
    bus.Addr = 32'h0000_1234; bus.Hit = 1'b1; bus.MemRead = 1'b1;
    @(negedge CLK); chk_all("lh0", 7'b0000010, 1'b1, 1'b0, 1'b0, 32'd0);
    tick();
    @(negedge CLK); chk_all("lh1", 7'b0000000, 1'b0, 1'b0, 1'b0, 32'd0);
    tick();
    bus.MemRead = 1'b0;
    @(negedge CLK); chk_all("lh2", 7'b0000000, 1'b0, 1'b0, 1'b0, 32'd0);
    tick();

    // Store hit, with MemRead also high (store wins)
    bus.Addr = 32'h0000_1238; bus.MemRead = 1'b1; bus.MemWrite = 1'b1;
    @(negedge CLK); chk_all("sh0", 7'b0000010, 1'b1, 1'b0, 1'b0, 32'd0);
    tick();
    @(negedge CLK); chk_all("sh1", 7'b1111001, 1'b0, 1'b0, 1'b0, 32'd0);
    tick();
    bus.MemRead = 1'b0; bus.MemWrite = 1'b0;
    @(negedge CLK); chk_all("sh2", 7'b0000000, 1'b0, 1'b0, 1'b0, 32'd0);
    tick();

    // Clean load miss, MemReady every cycle
    bus.Addr = 32'h0000_1230; bus.Hit = 1'b0; bus.Dirty = 1'b0;
    bus.MemReady = 1'b1; bus.MemRead = 1'b1;
    @(negedge CLK); chk_all("cm0", 7'b0000010, 1'b1, 1'b0, 1'b0, 32'd0);
    tick();
    @(negedge CLK); chk_all("cm1", 7'b0000000, 1'b1, 1'b0, 1'b0, 32'd0);
    tick();
    for (int i = 0; i < 4; i++) begin
      e = {1'b1, (i == 3), 1'b0, 2'(i), 2'b00};
      @(negedge CLK); chk_all($sformatf("cm_rd%0d", i), e, 1'b1, 1'b1, 1'b0, 32'h1230 + 32'(4 * i));
      if (i == 3) bus.Hit = 1'b1;
      tick();
    end
    @(negedge CLK); chk_all("cm6", 7'b0000000, 1'b0, 1'b0, 1'b0, 32'd0);
    tick();
    bus.MemRead = 1'b0;

    // Dirty miss: writeback burst then refill
    bus.Addr = 32'h0000_1220; bus.OutTag = 26'h15; bus.Hit = 1'b0; bus.Dirty = 1'b1;
    bus.MemRead = 1'b1;
    @(negedge CLK); chk_all("dm0", 7'b0000010, 1'b1, 1'b0, 1'b0, 32'd0);
    tick();
    @(negedge CLK); chk_all("dm1", 7'b0000000, 1'b1, 1'b0, 1'b0, 32'd0);
    tick();
    for (int i = 0; i < 4; i++) begin
      e = {3'b000, 2'(i), 2'b00};
      @(negedge CLK); chk_all($sformatf("dm_wb%0d", i), e, 1'b1, 1'b1, 1'b1, 32'h560 + 32'(4 * i));
      tick();
    end
    for (int i = 0; i < 4; i++) begin
      e = {1'b1, (i == 3), 1'b0, 2'(i), 2'b00};
      @(negedge CLK); chk_all($sformatf("dm_rd%0d", i), e, 1'b1, 1'b1, 1'b0, 32'h1220 + 32'(4 * i));
      if (i == 3) bus.Hit = 1'b1;
      tick();
    end
    @(negedge CLK); chk_all("dm_hit", 7'b0000000, 1'b0, 1'b0, 1'b0, 32'd0);
    tick();
    bus.MemRead = 1'b0; bus.Dirty = 1'b0;

    // Backpressure at cnt=1, then request withdrawn mid-burst
    bus.Addr = 32'h0000_1230; bus.Hit = 1'b0; bus.MemWrite = 1'b1; bus.MemReady = 1'b1;
    tick();
    tick();
    @(negedge CLK); chk_all("bp_rd0", 7'b1000000, 1'b1, 1'b1, 1'b0, 32'h1230);
    tick();
    bus.MemReady = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge CLK); chk_all($sformatf("bp_hold%0d", i), 7'b0000100, 1'b1, 1'b1, 1'b0, 32'h1234);
      tick();
    end
    bus.MemReady = 1'b1;
    @(negedge CLK); chk_all("bp_rd1", 7'b1000100, 1'b1, 1'b1, 1'b0, 32'h1234);
    tick();
    bus.MemWrite = 1'b0;
    @(negedge CLK); chk_all("bp_rd2", 7'b1001000, 1'b0, 1'b1, 1'b0, 32'h1238);
    tick();
    bus.Hit = 1'b1;
    @(negedge CLK); chk_all("bp_rd3", 7'b1101100, 1'b0, 1'b1, 1'b0, 32'h123C);
    tick();
    @(negedge CLK); chk_all("bp_chk", 7'b0000000, 1'b0, 1'b0, 1'b0, 32'd0);
    tick();
    @(negedge CLK); chk_all("bp_idle", 7'b0000000, 1'b0, 1'b0, 1'b0, 32'd0);
    tick();

    // Asynchronous reset in the middle of a refill
    bus.Addr = 32'h0000_1230; bus.Hit = 1'b0; bus.MemRead = 1'b1;
    tick();
    tick();
    tick();
    tick();
    @(negedge CLK); chk_all("mr_rd2", 7'b1001000, 1'b1, 1'b1, 1'b0, 32'h1238);
    #2 Reset = 1'b0;
    #1 chk_all("mr_rst", 7'b0000000, 1'b1, 1'b0, 1'b0, 32'd0);
    tick();
    tick();
    Reset = 1'b1;
    @(negedge CLK); chk_all("mr_restart", 7'b0000010, 1'b1, 1'b0, 1'b0, 32'd0);
    bus.MemRead = 1'b0;
    tick();
    @(negedge CLK); chk_all("mr_idle", 7'b0000000, 1'b0, 1'b0, 1'b0, 32'd0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

`default_nettype wire
